// File: rtl/encode_dp_wide_if.sv
// encode_dp_wide_if: source-word and output-beat bundle for encode_dp_wide.
// The master side drives source words and consumes output beats.
// The slave side is the datapath itself.
interface encode_dp_wide_if #(
    parameter int IN_BYTES  = 8,
    parameter int IDX_WIDTH = 20
);
    localparam int NBW = $clog2(IN_BYTES) + 1;

    logic [IN_BYTES*8-1:0]  src_data;
    logic                   src_valid;
    logic                   src_last;
    logic [NBW-1:0]         src_nbytes;
    logic                   src_ready;

    logic [7:0]             out_data;
    logic [IDX_WIDTH-1:0]   out_idx;
    logic                   out_valid;
    logic                   out_last;
    logic                   out_ready;

    logic                   hit_valid;
    logic [7:0]             hit_b0;
    logic [7:0]             hit_b1;
    logic [IDX_WIDTH-1:0]   hit_ref;

    modport master (
        output src_data, src_valid, src_last, src_nbytes, out_ready,
        input  src_ready, out_data, out_idx, out_valid, out_last,
        input  hit_valid, hit_b0, hit_b1, hit_ref
    );

    modport slave (
        input  src_data, src_valid, src_last, src_nbytes, out_ready,
        output src_ready, out_data, out_idx, out_valid, out_last,
        output hit_valid, hit_b0, hit_b1, hit_ref
    );
endinterface

// File: rtl/encode_dp_wide.sv
// encode_dp_wide: LZS encoder front-end. Serialises packed source words
// LSB-first into a byte stream with a running index, pairs each byte with a
// hash-table lookup of the preceding two-byte pair, and optionally records
// bytes in a history RAM.
// Optional feature: define ENCODE_DP_HIST_EN to build the 2^HIST_AW x 8
// history RAM; without it hraddr is ignored and hdata is constant zero.
module encode_dp_wide #(
    parameter int IN_BYTES  = 8,
    parameter int IDX_WIDTH = 20,
    parameter int HASH_BITS = 8,
    parameter int HIST_AW   = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    encode_dp_wide_if.slave    bus,
    input  logic [HIST_AW-1:0] hraddr,
    output logic [7:0]         hdata,
    output logic               init_done,
    output logic               done
);
    localparam int NBW   = $clog2(IN_BYTES) + 1;
    localparam int KW    = $clog2(IN_BYTES);
    localparam int HSIZE = 1 << HASH_BITS;
    // Table entry layout: {valid, b0, b1, ref}
    localparam int EW    = 1 + 8 + 8 + IDX_WIDTH;

    localparam logic [IDX_WIDTH-1:0] IDX_ONE  = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NBW-1:0]       NB_ONE   = {{(NBW-1){1'b0}}, 1'b1};
    localparam logic [NBW-1:0]       NB_FULL  = NBW'(IN_BYTES);
    localparam logic [HASH_BITS-1:0] HASH_ONE = {{(HASH_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [HASH_BITS-1:0]   clr_cnt_q, clr_cnt_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                   prev_valid_q, prev_valid_d;
    logic [7:0]             prev_byte_q, prev_byte_d;
    logic [IN_BYTES*8-1:0]  word_q, word_d;
    logic [NBW-1:0]         n_q, n_d;
    logic [NBW-1:0]         k_q, k_d;
    logic                   last_q, last_d;

    logic                   src_ready_q, src_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [7:0]             out_data_q, out_data_d;
    logic [IDX_WIDTH-1:0]   out_idx_q, out_idx_d;
    logic                   hit_valid_q, hit_valid_d;
    logic [7:0]             hit_b0_q, hit_b0_d;
    logic [7:0]             hit_b1_q, hit_b1_d;
    logic [IDX_WIDTH-1:0]   hit_ref_q, hit_ref_d;
    logic                   init_done_q, init_done_d;
    logic                   done_q, done_d;
    logic [7:0]             hdata_q, hdata_d;

    logic [EW-1:0]          tbl_mem [HSIZE];
    logic                   tbl_we_s;
    logic [HASH_BITS-1:0]   tbl_waddr_s;
    logic [EW-1:0]          tbl_wdata_s;
    logic [EW-1:0]          tbl_rdata_s;

    logic [7:0]             byte_s;
    logic [15:0]            pair_s;
    logic [HASH_BITS-1:0]   hash_s;
    logic                   adv_s;

    // Current byte, its pair with the previous byte, and the pair hash.
    assign byte_s      = word_q[{k_q[KW-1:0], 3'b000} +: 8];
    assign pair_s      = {prev_byte_q, byte_s};
    assign hash_s      = HASH_BITS'(pair_s ^ (pair_s >> (16 - HASH_BITS)));
    assign adv_s       = (state_q == S_EMIT) && (!out_valid_q || bus.out_ready);
    // Read-first table port: the value captured at an edge predates that edge's write.
    assign tbl_rdata_s = tbl_mem[hash_s];

    // Next-state, table write port and output register update.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        idx_d        = idx_q;
        prev_valid_d = prev_valid_q;
        prev_byte_d  = prev_byte_q;
        word_d       = word_q;
        n_d          = n_q;
        k_d          = k_q;
        last_d       = last_q;
        src_ready_d  = 1'b0;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        out_idx_d    = out_idx_q;
        hit_valid_d  = hit_valid_q;
        hit_b0_d     = hit_b0_q;
        hit_b1_d     = hit_b1_q;
        hit_ref_d    = hit_ref_q;
        init_done_d  = init_done_q;
        done_d       = done_q;
        tbl_we_s     = 1'b0;
        tbl_waddr_s  = clr_cnt_q;
        tbl_wdata_s  = {EW{1'b0}};

        // A pending beat taken by the consumer leaves the register empty.
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            S_INIT: begin
                tbl_we_s    = 1'b1;
                tbl_waddr_s = clr_cnt_q;
                tbl_wdata_s = {EW{1'b0}};
                clr_cnt_d   = clr_cnt_q + HASH_ONE;
                if (&clr_cnt_q) begin
                    init_done_d  = 1'b1;
                    idx_d        = {IDX_WIDTH{1'b0}};
                    prev_valid_d = 1'b0;
                    state_d      = S_LOAD;
                    src_ready_d  = 1'b1;
                end else begin
                    src_ready_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (bus.src_valid && src_ready_q) begin
                    word_d  = bus.src_data;
                    last_d  = bus.src_last;
                    k_d     = {NBW{1'b0}};
                    state_d = S_EMIT;
                    if (bus.src_last && (bus.src_nbytes != {NBW{1'b0}})) begin
                        n_d = bus.src_nbytes;
                    end else begin
                        n_d = NB_FULL;
                    end
                end else begin
                    src_ready_d = 1'b1;
                end
            end
            S_EMIT: begin
                if (adv_s) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = byte_s;
                    out_idx_d    = idx_q;
                    idx_d        = idx_q + IDX_ONE;
                    prev_byte_d  = byte_s;
                    prev_valid_d = 1'b1;
                    k_d          = k_q + NB_ONE;
                    if (prev_valid_q) begin
                        hit_valid_d = tbl_rdata_s[EW-1];
                        hit_b0_d    = tbl_rdata_s[EW-2 -: 8];
                        hit_b1_d    = tbl_rdata_s[EW-10 -: 8];
                        hit_ref_d   = tbl_rdata_s[IDX_WIDTH-1:0];
                        tbl_we_s    = 1'b1;
                        tbl_waddr_s = hash_s;
                        tbl_wdata_s = {1'b1, prev_byte_q, byte_s, idx_q - IDX_ONE};
                    end else begin
                        hit_valid_d = 1'b0;
                        hit_b0_d    = 8'h00;
                        hit_b1_d    = 8'h00;
                        hit_ref_d   = {IDX_WIDTH{1'b0}};
                    end
                    if (k_q == (n_q - NB_ONE)) begin
                        if (last_q) begin
                            out_last_d = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            out_last_d  = 1'b0;
                            state_d     = S_LOAD;
                            src_ready_d = 1'b1;
                        end
                    end else begin
                        out_last_d = 1'b0;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    done_d = 1'b1;
                end else begin
                    done_d = done_q;
                end
                if (start) begin
                    state_d     = S_INIT;
                    clr_cnt_d   = {HASH_BITS{1'b0}};
                    init_done_d = 1'b0;
                    done_d      = 1'b0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Control and output registers; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT;
            clr_cnt_q    <= {HASH_BITS{1'b0}};
            idx_q        <= {IDX_WIDTH{1'b0}};
            prev_valid_q <= 1'b0;
            prev_byte_q  <= 8'h00;
            word_q       <= {(IN_BYTES*8){1'b0}};
            n_q          <= {NBW{1'b0}};
            k_q          <= {NBW{1'b0}};
            last_q       <= 1'b0;
            src_ready_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= 8'h00;
            out_idx_q    <= {IDX_WIDTH{1'b0}};
            hit_valid_q  <= 1'b0;
            hit_b0_q     <= 8'h00;
            hit_b1_q     <= 8'h00;
            hit_ref_q    <= {IDX_WIDTH{1'b0}};
            init_done_q  <= 1'b0;
            done_q       <= 1'b0;
            hdata_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            idx_q        <= idx_d;
            prev_valid_q <= prev_valid_d;
            prev_byte_q  <= prev_byte_d;
            word_q       <= word_d;
            n_q          <= n_d;
            k_q          <= k_d;
            last_q       <= last_d;
            src_ready_q  <= src_ready_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            out_idx_q    <= out_idx_d;
            hit_valid_q  <= hit_valid_d;
            hit_b0_q     <= hit_b0_d;
            hit_b1_q     <= hit_b1_d;
            hit_ref_q    <= hit_ref_d;
            init_done_q  <= init_done_d;
            done_q       <= done_d;
            hdata_q      <= hdata_d;
        end
    end

    // Hash table storage: cleared entry by entry during init, one pair write per beat.
    always_ff @(posedge clk) begin
        if (tbl_we_s) begin
            tbl_mem[tbl_waddr_s] <= tbl_wdata_s;
        end
    end

`ifdef ENCODE_DP_HIST_EN
    localparam int HIST_SIZE = 1 << HIST_AW;
    logic [7:0] hist_mem [HIST_SIZE];

    // History RAM: each emitted byte lands at the low bits of its index.
    always_ff @(posedge clk) begin
        if (adv_s) begin
            hist_mem[idx_q[HIST_AW-1:0]] <= byte_s;
        end
    end

    assign hdata_d = hist_mem[hraddr];
`else
    logic unused_hraddr_s;
    assign unused_hraddr_s = ^hraddr;
    assign hdata_d         = 8'h00;
`endif

    assign bus.src_ready = src_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.hit_valid = hit_valid_q;
    assign bus.hit_b0    = hit_b0_q;
    assign bus.hit_b1    = hit_b1_q;
    assign bus.hit_ref   = hit_ref_q;
    assign hdata         = hdata_q;
    assign init_done     = init_done_q;
    assign done          = done_q;
endmodule
